// File: rtl/datamover_pkg.sv
// rtl/datamover_pkg.sv - DataMover command/status field layout and command packing helper
package datamover_pkg;

  localparam int DM_CMD_W    = 72;
  localparam int DM_BTT_LSB  = 0;
  localparam int DM_BTT_W    = 23;
  localparam int DM_TYPE_BIT = 23;
  localparam int DM_ADDR_LSB = 32;
  localparam int DM_ADDR_W   = 32;
  localparam int DM_TAG_LSB  = 64;
  localparam int DM_TAG_W    = 4;

  localparam logic DM_TYPE_INCR = 1'b1;

  localparam int DM_STS_TAG_LSB = 0;
  localparam int DM_STS_INTERR  = 4;
  localparam int DM_STS_DECERR  = 5;
  localparam int DM_STS_SLVERR  = 6;
  localparam int DM_STS_OKAY    = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  function automatic logic [DM_CMD_W-1:0] dm_pack_cmd(
    input logic [DM_TAG_W-1:0]  tag,
    input logic [DM_ADDR_W-1:0] addr,
    input logic [DM_BTT_W-1:0]  btt
  );
    logic [DM_CMD_W-1:0] cmd;
    cmd                             = '0;
    cmd[DM_TAG_LSB +: DM_TAG_W]     = tag;
    cmd[DM_ADDR_LSB +: DM_ADDR_W]   = addr;
    cmd[DM_TYPE_BIT]                = DM_TYPE_INCR;
    cmd[DM_BTT_LSB +: DM_BTT_W]     = btt;
    return cmd;
  endfunction

endpackage

// File: rtl/dm_id_fifo.sv
// rtl/dm_id_fifo.sv - in-order FIFO of requester ids awaiting DataMover status
module dm_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/datamover_cmd_arbiter.sv
// rtl/datamover_cmd_arbiter.sv - round-robin sharing of one DataMover cmd/sts channel pair
module datamover_cmd_arbiter
  import datamover_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*32-1:0]          req_addr,
  input  logic [N_REQ*23-1:0]          req_btt,
  output logic [N_REQ-1:0]             cpl_valid,
  output logic [7:0]                   cpl_status,
  output logic [71:0]                  cmd_tdata,
  output logic                         cmd_tvalid,
  input  logic                         cmd_tready,
  input  logic [7:0]                   sts_tdata,
  input  logic                         sts_tvalid,
  output logic                         sts_tready,
  output logic [$clog2(OUT_DEPTH):0]   outstanding,
  output logic                         tag_error
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [71:0]       cmd_q, cmd_d;
  logic              armed_q, armed_d;
  logic [N_REQ-1:0]  cpl_valid_q, cpl_valid_d;
  logic [7:0]        cpl_status_q, cpl_status_d;
  logic              tag_error_q, tag_error_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  int                idx;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   fifo_head;

  assign cmd_tvalid = (state_q == ST_ISSUE);
  assign cmd_tdata  = cmd_q;
  assign cpl_valid  = cpl_valid_q;
  assign cpl_status = cpl_status_q;
  assign tag_error  = tag_error_q;
  assign sts_tready = 1'b1;

  // Search starts one past the last winner so every requester gets a turn
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    armed_d   = 1'b1;
    req_ready = '0;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && gnt_found && !fifo_full) begin
          req_ready[gnt_idx] = 1'b1;
          cmd_d   = dm_pack_cmd(DM_TAG_W'(gnt_idx),
                                req_addr[32*gnt_idx +: 32],
                                req_btt[23*gnt_idx +: 23]);
          rr_d    = gnt_idx;
          gnt_d   = gnt_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_tready) begin
          fifo_push = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completions are routed in issue order; a tag mismatch is flagged but not re-routed
  always_comb begin
    cpl_valid_d  = '0;
    cpl_status_d = cpl_status_q;
    tag_error_d  = tag_error_q;
    fifo_pop     = 1'b0;
    if (sts_tvalid) begin
      if (!fifo_empty) begin
        fifo_pop               = 1'b1;
        cpl_valid_d[fifo_head] = 1'b1;
        cpl_status_d           = sts_tdata;
        if (sts_tdata[DM_STS_TAG_LSB +: DM_TAG_W] != DM_TAG_W'(fifo_head)) begin
          tag_error_d = 1'b1;
        end
      end else begin
        tag_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      rr_q         <= ID_W'(N_REQ - 1);
      gnt_q        <= '0;
      cmd_q        <= '0;
      armed_q      <= 1'b0;
      cpl_valid_q  <= '0;
      cpl_status_q <= '0;
      tag_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      armed_q      <= armed_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_status_q <= cpl_status_d;
      tag_error_q  <= tag_error_d;
    end
  end

  dm_id_fifo #(
    .W     (ID_W),
    .DEPTH (OUT_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (aresetn),
    .push      (fifo_push),
    .push_data (gnt_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_datamover_cmd_arbiter.sv
// tb/tb_datamover_cmd_arbiter.sv - randomized self-checking bench against a queue-based model
module tb_datamover_cmd_arbiter;

  localparam int N_REQ     = 4;
  localparam int OUT_DEPTH = 8;

  logic                clk = 1'b0;
  logic                aresetn = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_addr = '0;
  logic [N_REQ*23-1:0] req_btt = '0;
  logic [N_REQ-1:0]    cpl_valid;
  logic [7:0]          cpl_status;
  logic [71:0]         cmd_tdata;
  logic                cmd_tvalid;
  logic                cmd_tready = 1'b0;
  logic [7:0]          sts_tdata = '0;
  logic                sts_tvalid = 1'b0;
  logic                sts_tready;
  logic [3:0]          outstanding;
  logic                tag_error;

  datamover_cmd_arbiter #(.N_REQ(N_REQ), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_btt     (req_btt),
    .cpl_valid   (cpl_valid),
    .cpl_status  (cpl_status),
    .cmd_tdata   (cmd_tdata),
    .cmd_tvalid  (cmd_tvalid),
    .cmd_tready  (cmd_tready),
    .sts_tdata   (sts_tdata),
    .sts_tvalid  (sts_tvalid),
    .sts_tready  (sts_tready),
    .outstanding (outstanding),
    .tag_error   (tag_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus staged for the next cycle
  logic [N_REQ-1:0] s_valid = '0;
  logic [31:0]      s_addr [N_REQ];
  logic [22:0]      s_btt  [N_REQ];
  logic             s_rdy  = 1'b0;
  logic             s_stsv = 1'b0;
  logic [7:0]       s_sts  = '0;

  // reference model: queue of owners in issue order plus the pending command
  int          m_q[$];
  bit          m_issue;
  int          m_gnt;
  logic [71:0] m_cmd;
  int          m_rr;
  bit          m_armed;
  logic [3:0]  e_cplv;
  logic [7:0]  e_cpls;
  bit          e_terr;

  int          gnt_log[$];
  logic [71:0] cmd_seen[$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    if (m_issue || !m_armed || m_q.size() >= OUT_DEPTH) return -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (m_rr + k) % N_REQ;
      if (s_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_issue = 0;
    m_gnt   = 0;
    m_cmd   = '0;
    m_rr    = N_REQ - 1;
    m_armed = 0;
    e_cplv  = '0;
    e_cpls  = '0;
    e_terr  = 0;
  endtask

  task automatic body();
    int g;
    logic [3:0] exp_rdy;
    check("cmd_tvalid", cmd_tvalid, m_issue);
    check("cmd_tdata", cmd_tdata, m_cmd);
    check("cpl_valid", cpl_valid, e_cplv);
    if (e_cplv != 0) check("cpl_status", cpl_status, e_cpls);
    check("outstanding", outstanding, m_q.size());
    check("tag_error", tag_error, e_terr);
    check("sts_tready", sts_tready, 1'b1);
    req_valid = s_valid;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[32*i +: 32] = s_addr[i];
      req_btt[23*i +: 23]  = s_btt[i];
    end
    cmd_tready = s_rdy;
    sts_tvalid = s_stsv;
    sts_tdata  = s_sts;
    #1;
    g = pick();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
    check("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gnt_log.push_back(i);
    if (cmd_tvalid && s_rdy) cmd_seen.push_back(cmd_tdata);
    e_cplv = '0;
    if (s_stsv) begin
      if (m_q.size() > 0) begin
        int h;
        h = m_q.pop_front();
        e_cplv[h] = 1'b1;
        e_cpls    = s_sts;
        if (int'(s_sts[3:0]) != h) e_terr = 1;
      end else begin
        e_terr = 1;
      end
    end
    if (m_issue && s_rdy) begin
      m_q.push_back(m_gnt);
      m_issue = 0;
    end
    if (g >= 0) begin
      m_gnt   = g;
      m_cmd   = {4'h0, 4'(g), s_addr[g], 8'h00, 1'b1, s_btt[g]};
      m_rr    = g;
      m_issue = 1;
    end
    m_armed = 1;
    @(posedge clk);
  endtask

  task automatic cycle();
    @(negedge clk);
    body();
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    req_valid = '1;
    #1;
    check("rst_cmd_tvalid", cmd_tvalid, 1'b0);
    check("rst_cmd_tdata", cmd_tdata, 72'h0);
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_outstanding", outstanding, 4'h0);
    check("rst_tag_error", tag_error, 1'b0);
    check("rst_cpl_valid", cpl_valid, 4'h0);
    model_reset();
    s_valid = '0;
    s_rdy   = 1'b0;
    s_stsv  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    body();
  endtask

  initial begin
    logic [71:0] lit_cmd;
    for (int i = 0; i < N_REQ; i++) begin
      s_addr[i] = '0;
      s_btt[i]  = '0;
    end
    model_reset();

    // single request from requester 0
    do_reset();
    s_valid = 4'b0001; s_addr[0] = 32'h1000; s_btt[0] = 23'h1000; s_rdy = 1'b1;
    gnt_log.delete(); cmd_seen.delete();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (gnt_log.size() > 0) s_valid = '0;
    end
    lit_cmd = 72'h00_00001000_00801000;
    check("single_grants", gnt_log.size(), 1);
    check("single_cmd_count", cmd_seen.size(), 1);
    check("single_cmd", (cmd_seen.size() > 0) ? cmd_seen[0] : 72'h0, lit_cmd);
    #1 check("single_outstanding_1", outstanding, 4'd1);
    s_stsv = 1'b1; s_sts = 8'h80;
    cycle();
    s_stsv = 1'b0;
    #1;
    check("single_cpl_valid", cpl_valid, 4'b0001);
    check("single_cpl_status", cpl_status, 8'h80);
    check("single_outstanding_0", outstanding, 4'd0);

    // round robin with all requesters active, then fill to OUT_DEPTH
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      s_addr[i] = $urandom; s_btt[i] = 23'($urandom);
    end
    s_valid = 4'hf; s_rdy = 1'b1;
    gnt_log.delete();
    repeat (22) cycle();
    check("fill_grants", gnt_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check("rr_order", (i < gnt_log.size()) ? gnt_log[i] : 99, i % N_REQ);
    #1 check("fill_outstanding", outstanding, 4'd8);
    s_stsv = 1'b1; s_sts = 8'h80;
    cycle();
    s_stsv = 1'b0;
    repeat (3) cycle();
    check("refill_grants", gnt_log.size(), 9);
    check("refill_gnt", (gnt_log.size() > 8) ? gnt_log[8] : 99, 0);

    // wrong tag: head owner is 1, status carries tag 2
    s_valid = '0;
    cycle();
    s_stsv = 1'b1; s_sts = 8'h82;
    cycle();
    s_stsv = 1'b0;
    #1;
    check("mis_cpl_valid", cpl_valid, 4'b0010);
    check("mis_tag_error", tag_error, 1'b1);

    // back-pressure on the command channel
    do_reset();
    s_valid = 4'hf; s_rdy = 1'b0;
    gnt_log.delete();
    repeat (12) cycle();
    check("stall_grants", gnt_log.size(), 1);
    #1;
    check("stall_cmd_tvalid", cmd_tvalid, 1'b1);
    check("stall_cmd_tdata", cmd_tdata, {4'h0, 4'h0, s_addr[0], 8'h00, 1'b1, s_btt[0]});

    // reset while a command is pending, then requester 0 wins first again
    do_reset();
    s_valid = 4'hf; s_rdy = 1'b1;
    gnt_log.delete();
    repeat (3) cycle();
    check("rst_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);

    // status with nothing outstanding
    do_reset();
    s_stsv = 1'b1; s_sts = 8'h80;
    cycle();
    s_stsv = 1'b0;
    #1;
    check("empty_cpl_valid", cpl_valid, 4'h0);
    check("empty_tag_error", tag_error, 1'b1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      s_valid = 4'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        s_addr[i] = $urandom;
        s_btt[i]  = ($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom);
      end
      s_rdy = ($urandom_range(0, 3) != 0);
      s_stsv = 1'b0;
      if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        s_stsv = 1'b1;
        s_sts  = {4'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(m_q[0])};
      end else if (m_q.size() == 0 && $urandom_range(0, 199) == 0) begin
        s_stsv = 1'b1;
        s_sts  = 8'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
